qspim_rx_fifo: RTL and testbench

- Receive-data buffer directly downstream of the QSPI receive shifter.
- Accepts assembled, already endian-ordered 32-bit words on a valid/ready handshake: wr_valid is the shifter's single-cycle data_valid pulse, and wr_ready drives its data_ready.
- Presents the words first-word-fall-through to the bus read master, with an end-of-transfer tag per word.
- Decouples flash-side shifting from bus-side stalls, so the shifter only waits in its FIFO-wait states when this buffer is genuinely full.

---
 rtl/qspim_pkg.sv | 20 ++
 rtl/qspim_rx_fifo_if.sv | 29 ++
 rtl/qspim_fifo_mem.sv | 29 ++
 rtl/qspim_rx_fifo.sv | 112 +++++++++++
 tb/tb_qspim_rx_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/qspim_pkg.sv
// Shared QSPI master definitions: bus width, default receive-buffer depth
// and the receive-buffer entry layout.
package qspim_pkg;

    localparam int QSPIM_DW        = 32;
    localparam int QSPIM_RXF_DEPTH = 8;

    typedef struct packed {
        logic                last;
        logic [QSPIM_DW-1:0] data;
    } qspim_rxf_entry_t;

    // True when the free entries left at this occupancy are at or below the threshold.
    function automatic logic rxf_almost_full(input int unsigned occupancy,
                                             input int unsigned depth,
                                             input int unsigned afull_th);
        return (depth - occupancy) <= afull_th;
    endfunction

endpackage

// File: rtl/qspim_rx_fifo_if.sv
// Write (shifter side) and read (bus side) handshakes of the QSPI receive buffer.
// master drives writes and consumes reads; slave is the buffer itself.
interface qspim_rx_fifo_if
    import qspim_pkg::*;
#(
    parameter int DW = QSPIM_DW
);

    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_valid;
    logic          wr_ready;

    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output wr_data, wr_last, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_last, rd_valid
    );

    modport slave (
        input  wr_data, wr_last, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_last, rd_valid
    );

endinterface

// File: rtl/qspim_fifo_mem.sv
// DEPTH-entry register array for the receive buffer: synchronous write,
// asynchronous read so the head word falls through without a read cycle.
module qspim_fifo_mem
    import qspim_pkg::*;
#(
    parameter int DEPTH = QSPIM_RXF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  qspim_rxf_entry_t wr_entry,
    input  logic [AW-1:0]    rd_addr,
    output qspim_rxf_entry_t rd_entry
);

    qspim_rxf_entry_t mem [DEPTH];

    // NOTE: storage is deliberately not reset; entry validity is tracked by the
    // occupancy counter, so a never-written slot is never presented as valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/qspim_rx_fifo.sv
// QSPI receive buffer: first-word-fall-through FIFO with last-word tags and sticky overflow.
// Define QSPIM_RX_FIFO_STATS_EN to build the max_level high-water-mark register.
module qspim_rx_fifo
    import qspim_pkg::*;
#(
    parameter int DW       = QSPIM_DW,
    parameter int DEPTH    = QSPIM_RXF_DEPTH,
    parameter int AFULL_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    qspim_rx_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow_err,
    output logic [$clog2(DEPTH):0]   max_level
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_next;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_drop;
    logic [DW-1:0]    head_data;
    qspim_rxf_entry_t wr_entry;
    qspim_rxf_entry_t rd_entry;

    // Full and empty come from the occupancy count, so pointer equality is never ambiguous.
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // Flush outranks both handshakes: nothing is accepted and no overflow is flagged.
    assign wr_acc  = bus.wr_valid && !full  && !flush;
    assign rd_acc  = bus.rd_ready && !empty && !flush;
    assign wr_drop = bus.wr_valid &&  full  && !flush;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc) begin
            level_next = level + LEVEL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_next = level - LEVEL_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_next;
            if (wr_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef QSPIM_RX_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            max_level <= '0;
        end else if (level_next > max_level) begin
            max_level <= level_next;
        end
    end
`else
    assign max_level = '0;
`endif

    assign wr_entry = '{last: bus.wr_last, data: QSPIM_DW'(bus.wr_data)};

    qspim_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_acc),
        .wr_addr  (wr_ptr),
        .wr_entry (wr_entry),
        .rd_addr  (rd_ptr),
        .rd_entry (rd_entry)
    );

    assign head_data    = DW'(rd_entry.data);
    assign bus.rd_data  = head_data;
    assign bus.rd_last  = rd_entry.last;
    assign bus.rd_valid = !empty;
    assign bus.wr_ready = !full;
    assign almost_full  = rxf_almost_full(32'(level), DEPTH, AFULL_TH);

endmodule

// File: tb/tb_qspim_rx_fifo.sv
// Self-checking bench for qspim_rx_fifo: vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_qspim_rx_fifo;
    import qspim_pkg::*;

    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 2;
    localparam int AW       = $clog2(DEPTH);
`ifdef QSPIM_RX_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW:0]   level;
    logic [AW:0]   max_level;
    logic          almost_full;
    logic          overflow_err;

    qspim_rx_fifo_if #(.DW(32)) bus ();

    qspim_rx_fifo #(
        .DW       (32),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .level        (level),
        .almost_full  (almost_full),
        .overflow_err (overflow_err),
        .max_level    (max_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered queue of stored words plus the sticky flag and high-water mark.
    qspim_rxf_entry_t q[$];
    bit               m_ovf = 1'b0;
    int               m_max = 0;

    task automatic model_step(input bit wv, input logic [31:0] wd, input bit wl,
                              input bit rr, input bit fl, input bit rs);
        int n;
        bit wacc;
        bit racc;
        n = q.size();
        if (rs || fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_max = 0;
            return;
        end
        wacc = wv && (n < DEPTH);
        racc = rr && (n > 0);
        if (wv && n == DEPTH) m_ovf = 1'b1;
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back('{last: wl, data: wd});
        if (q.size() > m_max) m_max = q.size();
    endtask

    task automatic apply(input bit wv, input logic [31:0] wd, input bit wl,
                         input bit rr, input bit fl, input bit rs);
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.wr_last  = wl;
        bus.rd_ready = rr;
        flush        = fl;
        rst          = rs;
        @(posedge clk);
        model_step(wv, wd, wl, rr, fl, rs);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_level"},  level,        q.size());
        check({tag, "_valid"},  bus.rd_valid, q.size() != 0);
        check({tag, "_wready"}, bus.wr_ready, q.size() < DEPTH);
        check({tag, "_afull"},  almost_full,  (DEPTH - q.size()) <= AFULL_TH);
        check({tag, "_ovf"},    overflow_err, m_ovf);
        check({tag, "_max"},    max_level,    STATS ? m_max : 0);
        if (q.size() != 0) begin
            check({tag, "_data"}, bus.rd_data, q[0].data);
            check({tag, "_last"}, bus.rd_last, q[0].last);
        end
    endtask

    typedef struct {
        bit          wv;
        logic [31:0] wd;
        bit          wl;
        bit          rr;
        bit          fl;
        bit          rs;
        int          e_level;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_last;
        bit          e_ovf;
        bit          e_wready;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int next_head;
        int wprob;
        int rprob;
        bit wv;
        bit rr;
        bit fl;
        bit rs;

        rst          = 1'b1;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        bus.rd_ready = 1'b0;

        //               wv  wd             wl rr fl rs  lvl v  data           last ovf wrdy
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h11,       1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h11,       1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h22,       1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h22,       1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h33,       1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h22,       1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h44,       1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h55,       1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h55,       1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            apply(vecs[i].wv, vecs[i].wd, vecs[i].wl, vecs[i].rr, vecs[i].fl, vecs[i].rs);
            check($sformatf("vec%0d_level", i),  level,        vecs[i].e_level);
            check($sformatf("vec%0d_valid", i),  bus.rd_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_ovf", i),    overflow_err, vecs[i].e_ovf);
            check($sformatf("vec%0d_wready", i), bus.wr_ready, vecs[i].e_wready);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), bus.rd_data, vecs[i].e_data);
                check($sformatf("vec%0d_last", i), bus.rd_last, vecs[i].e_last);
            end
        end

        // Fill to full, overflow once, then drain in order.
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            apply(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            check("fill_level", level, i);
            check("fill_afull", almost_full, i >= 6);
            check_model("fill");
        end
        check("full_wready", bus.wr_ready, 1'b0);
        apply(1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow_err, 1'b1);
        check("ovf_level", level, DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_data", bus.rd_data, i);
            apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_model("drain");
        end
        check("ovf_sticky", overflow_err, 1'b1);
        idle();
        check("drained_valid", bus.rd_valid, 1'b0);

        // Steady occupancy of 4 with simultaneous read and write across the pointer wrap.
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_model("steady_flush");
        for (int i = 0; i < 4; i++) apply(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        next_head = 32'h100;
        for (int k = 0; k < 20; k++) begin
            check("steady_head", bus.rd_data, next_head);
            apply(1'b1, 32'h104 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0);
            next_head++;
            check("steady_level", level, 4);
        end
        check("steady_max", max_level, STATS ? 4 : 0);
        check_model("steady");

        // Last tags on a three-word transfer.
        apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("tag_last", bus.rd_last, i == 2);
            apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_model("tag_end");

        // Flush colliding with a write and a read.
        for (int i = 0; i < 5; i++) apply(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'hF5, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flush_level", level, 0);
        check("flush_valid", bus.rd_valid, 1'b0);
        check("flush_ovf", overflow_err, 1'b0);
        idle();
        check("flush_nostore", level, 0);

        // Reset in the middle of a fill.
        for (int i = 0; i < 3; i++) apply(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("prerst_level", level, 3);
        apply(1'b1, 32'hE3, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_level", level, 0);
        check("rst_valid", bus.rd_valid, 1'b0);
        check("rst_wready", bus.wr_ready, 1'b1);
        check("rst_afull", almost_full, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        check("rst_max", max_level, 0);
        apply(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("postrst_data", bus.rd_data, 32'hDEADBEEF);
        check_model("postrst");

        // Randomized traffic; write/read bias changes per segment to visit full and empty.
        for (int seg = 0; seg < 6; seg++) begin
            wprob = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 30 : 55;
            rprob = (seg % 3 == 0) ? 30 : (seg % 3 == 1) ? 80 : 55;
            for (int c = 0; c < 100; c++) begin
                wv = $urandom_range(0, 99) < wprob;
                rr = $urandom_range(0, 99) < rprob;
                fl = $urandom_range(0, 99) < 2;
                rs = $urandom_range(0, 199) < 1;
                apply(wv, $urandom(), 1'($urandom_range(0, 1)), rr, fl, rs);
                check_model("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
